// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter_mod: the master drives count controls,
// the slave (the counter) returns registered count and limit flags.
interface updown_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, dir, load, load_val,
        input  count, tc, at_max, at_min
    );

    modport slave (
        input  en, dir, load, load_val,
        output count, tc, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus MAX_VAL+1, clamped parallel load and tc pulse.
// Define UPDOWN_CNT_SAT_EN to saturate at the limits instead of wrapping.
module updown_counter_mod #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input logic               clk,
    input logic               rst,
    updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             at_max_r;
    logic             at_min_r;
    logic [WIDTH-1:0] next_count_s;
    logic             next_tc_s;

    // Next-state count and terminal flag; priority is load over en.
    always_comb begin
        next_count_s = count_r;
        next_tc_s    = 1'b0;
        if (bus.load) begin
            if (bus.load_val > MAX_VAL) begin
                next_count_s = MAX_VAL;
            end else begin
                next_count_s = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.dir) begin
                if (count_r == MAX_VAL) begin
`ifdef UPDOWN_CNT_SAT_EN
                    next_count_s = MAX_VAL;
`else
                    next_count_s = ZERO;
`endif
                    next_tc_s    = 1'b1;
                end else begin
                    next_count_s = count_r + STEP;
                end
            end else begin
                if (count_r == ZERO) begin
`ifdef UPDOWN_CNT_SAT_EN
                    next_count_s = ZERO;
`else
                    next_count_s = MAX_VAL;
`endif
                    next_tc_s    = 1'b1;
                end else begin
                    next_count_s = count_r - STEP;
                end
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // State register; limit flags derive from next count so they stay coherent with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= RST_VAL;
            tc_r     <= 1'b0;
            at_max_r <= (RST_VAL == MAX_VAL);
            at_min_r <= (RST_VAL == ZERO);
        end else begin
            count_r  <= next_count_s;
            tc_r     <= next_tc_s;
            at_max_r <= (next_count_s == MAX_VAL);
            at_min_r <= (next_count_s == ZERO);
        end
    end

    assign bus.count  = count_r;
    assign bus.tc     = tc_r;
    assign bus.at_max = at_max_r;
    assign bus.at_min = at_min_r;
endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod (WIDTH=3, MAX_VAL=5): directed plan then random traffic.
module tb_updown_counter_mod;
    localparam int W   = 3;
    localparam int MAX = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    updown_counter_if #(.WIDTH(W)) bus ();

    updown_counter_mod #(.WIDTH(W), .MAX_VAL(3'd5), .RST_VAL(3'd0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     cnt;
        bit     tc;
        bit     mx;
        bit     mn;
        longint edge_no;
    } exp_t;

    exp_t   sb[$];
    longint edges  = 0;
    int     errors = 0;
    int     checks = 0;
    int     m_cnt  = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Monitor: compare every expected entry whose edge has occurred.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_no <= edges) begin
            exp_t e;
            e = sb.pop_front();
            chk("count",  int'(bus.count),  e.cnt);
            chk("tc",     int'(bus.tc),     int'(e.tc));
            chk("at_max", int'(bus.at_max), int'(e.mx));
            chk("at_min", int'(bus.at_min), int'(e.mn));
        end
    end

    // Drive one edge worth of inputs and push the reference result.
    task automatic step(input bit r, input bit e, input bit d, input bit l, input int lv,
                        input bit glitch = 1'b0);
        exp_t x;
        bit   t;
        @(posedge clk);
        #1;
        if (glitch) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
        end
        rst          = r;
        bus.en       = e;
        bus.dir      = d;
        bus.load     = l;
        bus.load_val = lv[W-1:0];
        t = 1'b0;
        if (r) begin
            m_cnt = 0;
        end else if (l) begin
            m_cnt = (lv > MAX) ? MAX : lv;
        end else if (e) begin
`ifdef UPDOWN_CNT_SAT_EN
            if (d) begin t = (m_cnt == MAX); m_cnt = (m_cnt + 1 > MAX) ? MAX : m_cnt + 1; end
            else   begin t = (m_cnt == 0);   m_cnt = (m_cnt - 1 < 0)   ? 0   : m_cnt - 1; end
`else
            if (d) begin t = (m_cnt == MAX); m_cnt = (m_cnt + 1) % (MAX + 1); end
            else   begin t = (m_cnt == 0);   m_cnt = (m_cnt + MAX) % (MAX + 1); end
`endif
        end
        x.cnt = m_cnt;
        x.tc  = t;
        x.mx  = (m_cnt == MAX);
        x.mn  = (m_cnt == 0);
        x.edge_no = edges + 1;
        sb.push_back(x);
    endtask

    initial begin
        bus.en = 1'b0; bus.dir = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        // reset dominates load/en
        step(1'b1, 1'b1, 1'b1, 1'b1, 3);
        // up wrap: 1,2,3,4,5,0,1
        repeat (7) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        // down wrap from 0: 5,4,3
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        // clamped load, then reset beats load
        step(1'b0, 1'b1, 1'b0, 1'b1, 7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2);
        // direction toggle and hold from 3, with a between-edge rst glitch
        step(1'b0, 1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        // pushing into the limits (saturates or wraps depending on build)
        step(1'b0, 1'b0, 1'b0, 1'b1, 5);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 7)));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
